// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing one registered CDB between ex, ld and st result FIFOs
// Ports: clk_in/rst_in (async active-high), rdy_in global enable, clear_branch_in flush,
//        {ex,ld,st}_valid_in/_ready_out push handshakes with their tag/result fields,
//        cdb_* registered broadcast (src 0=ex, 1=ld, 2=st).
module cdb_arbiter #(
    parameter int ROB_IDX_W = 4,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int QDEPTH    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_branch_in,
    input  logic                 ex_valid_in,
    output logic                 ex_ready_out,
    input  logic [ROB_IDX_W-1:0] ex_rob_pos_in,
    input  logic [WORD_W-1:0]    ex_res_in,
    input  logic                 ex_jump_en_in,
    input  logic [ADDR_W-1:0]    ex_jump_a_in,
    input  logic                 ld_valid_in,
    output logic                 ld_ready_out,
    input  logic [ROB_IDX_W-1:0] ld_rob_pos_in,
    input  logic [WORD_W-1:0]    ld_res_in,
    input  logic                 st_valid_in,
    output logic                 st_ready_out,
    input  logic [ROB_IDX_W-1:0] st_rob_pos_in,
    output logic                 cdb_valid_out,
    output logic [1:0]           cdb_src_out,
    output logic [ROB_IDX_W-1:0] cdb_rob_pos_out,
    output logic [WORD_W-1:0]    cdb_res_out,
    output logic                 cdb_jump_en_out,
    output logic [ADDR_W-1:0]    cdb_jump_a_out
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [2:0]           vld, rdy, push, pop, ne, jen_in;
    logic [ROB_IDX_W-1:0] pos_in [3];
    logic [WORD_W-1:0]    res_in [3];
    logic [ADDR_W-1:0]    ja_in  [3];
    logic [ROB_IDX_W-1:0] pos_m  [3][QDEPTH];
    logic [WORD_W-1:0]    res_m  [3][QDEPTH];
    logic                 jen_m  [3][QDEPTH];
    logic [ADDR_W-1:0]    ja_m   [3][QDEPTH];
    logic [CW-1:0]        cnt_q  [3];
    logic [PW-1:0]        rp_q   [3];
    logic [PW-1:0]        wp_q   [3];
    logic [1:0]           lg_q, g0, g1, g2, gsel;
    logic                 en, any;

    function automatic logic [1:0] nxt(input logic [1:0] s);
        return s == 2'd2 ? 2'd0 : s + 2'd1;
    endfunction

    // ld/st carry zero jump fields and st a zero result, so the CDB load needs no per-source muxing
    assign vld       = {st_valid_in, ld_valid_in, ex_valid_in};
    assign jen_in    = {1'b0, 1'b0, ex_jump_en_in};
    assign pos_in[0] = ex_rob_pos_in;
    assign pos_in[1] = ld_rob_pos_in;
    assign pos_in[2] = st_rob_pos_in;
    assign res_in[0] = ex_res_in;
    assign res_in[1] = ld_res_in;
    assign res_in[2] = '0;
    assign ja_in[0]  = ex_jump_a_in;
    assign ja_in[1]  = '0;
    assign ja_in[2]  = '0;

    assign en   = rdy_in && !clear_branch_in;
    assign any  = |ne;
    assign g0   = nxt(lg_q);
    assign g1   = nxt(g0);
    assign g2   = nxt(g1);
    assign gsel = ne[g0] ? g0 : ne[g1] ? g1 : g2;

    for (genvar i = 0; i < 3; i++) begin : g_src
        assign ne[i]   = cnt_q[i] != '0;
        assign rdy[i]  = cnt_q[i] != CW'(QDEPTH);
        assign push[i] = vld[i] && rdy[i] && en;
        assign pop[i]  = en && any && gsel == 2'(i);
    end

    assign ex_ready_out = rdy[0];
    assign ld_ready_out = rdy[1];
    assign st_ready_out = rdy[2];

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                pos_m[s][wp_q[s]] <= pos_in[s];
                res_m[s][wp_q[s]] <= res_in[s];
                jen_m[s][wp_q[s]] <= jen_in[s];
                ja_m[s][wp_q[s]]  <= ja_in[s];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < 3; s++) begin
                cnt_q[s] <= '0;
                rp_q[s]  <= '0;
                wp_q[s]  <= '0;
            end
            lg_q            <= 2'd2;
            cdb_valid_out   <= 1'b0;
            cdb_src_out     <= '0;
            cdb_rob_pos_out <= '0;
            cdb_res_out     <= '0;
            cdb_jump_en_out <= 1'b0;
            cdb_jump_a_out  <= '0;
        end else if (rdy_in) begin
            if (clear_branch_in) begin
                for (int s = 0; s < 3; s++) begin
                    cnt_q[s] <= '0;
                    rp_q[s]  <= '0;
                    wp_q[s]  <= '0;
                end
                lg_q          <= 2'd2;
                cdb_valid_out <= 1'b0;
            end else begin
                for (int s = 0; s < 3; s++) begin
                    wp_q[s]  <= wp_q[s] + PW'(push[s]);
                    rp_q[s]  <= rp_q[s] + PW'(pop[s]);
                    cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
                end
                cdb_valid_out <= any;
                if (any) begin
                    lg_q            <= gsel;
                    cdb_src_out     <= gsel;
                    cdb_rob_pos_out <= pos_m[gsel][rp_q[gsel]];
                    cdb_res_out     <= res_m[gsel][rp_q[gsel]];
                    cdb_jump_en_out <= jen_m[gsel][rp_q[gsel]];
                    cdb_jump_a_out  <= ja_m[gsel][rp_q[gsel]];
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for cdb_arbiter
module tb_cdb_arbiter;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clear_branch_in = 1'b0;
    logic        ex_valid_in = 1'b0, ld_valid_in = 1'b0, st_valid_in = 1'b0;
    logic        ex_ready_out, ld_ready_out, st_ready_out;
    logic [3:0]  ex_rob_pos_in = '0, ld_rob_pos_in = '0, st_rob_pos_in = '0;
    logic [31:0] ex_res_in = '0, ld_res_in = '0, ex_jump_a_in = '0;
    logic        ex_jump_en_in = 1'b0;
    logic        cdb_valid_out, cdb_jump_en_out;
    logic [1:0]  cdb_src_out;
    logic [3:0]  cdb_rob_pos_out;
    logic [31:0] cdb_res_out, cdb_jump_a_out;
    int          nvec = 0, nerr = 0;

    cdb_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_branch_in(clear_branch_in),
        .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out), .ex_rob_pos_in(ex_rob_pos_in),
        .ex_res_in(ex_res_in), .ex_jump_en_in(ex_jump_en_in), .ex_jump_a_in(ex_jump_a_in),
        .ld_valid_in(ld_valid_in), .ld_ready_out(ld_ready_out), .ld_rob_pos_in(ld_rob_pos_in),
        .ld_res_in(ld_res_in),
        .st_valid_in(st_valid_in), .st_ready_out(st_ready_out), .st_rob_pos_in(st_rob_pos_in),
        .cdb_valid_out(cdb_valid_out), .cdb_src_out(cdb_src_out), .cdb_rob_pos_out(cdb_rob_pos_out),
        .cdb_res_out(cdb_res_out), .cdb_jump_en_out(cdb_jump_en_out), .cdb_jump_a_out(cdb_jump_a_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Result fields are derived from the tag so each broadcast can be checked field by field.
    task automatic drive(input logic exv, input logic [3:0] exp, input logic ldv, input logic [3:0] ldp,
                         input logic stv, input logic [3:0] stp);
        ex_valid_in   = exv;
        ex_rob_pos_in = exp;
        ex_res_in     = 32'hE000_0000 | 32'(exp);
        ex_jump_en_in = exp[0];
        ex_jump_a_in  = 32'h0000_A000 | 32'(exp);
        ld_valid_in   = ldv;
        ld_rob_pos_in = ldp;
        ld_res_in     = 32'hD000_0000 | 32'(ldp);
        st_valid_in   = stv;
        st_rob_pos_in = stp;
    endtask

    task automatic expect_cdb(input string tag, input logic v, input logic [1:0] src, input logic [3:0] pos);
        chk({tag, ".valid"}, 64'(cdb_valid_out), 64'(v));
        if (v) begin
            chk({tag, ".src"}, 64'(cdb_src_out), 64'(src));
            chk({tag, ".pos"}, 64'(cdb_rob_pos_out), 64'(pos));
            chk({tag, ".res"}, 64'(cdb_res_out), src == 2'd0 ? 64'(32'hE000_0000 | 32'(pos)) :
                                                 src == 2'd1 ? 64'(32'hD000_0000 | 32'(pos)) : 64'd0);
            chk({tag, ".jen"}, 64'(cdb_jump_en_out), src == 2'd0 ? 64'(pos[0]) : 64'd0);
            chk({tag, ".ja"}, 64'(cdb_jump_a_out), src == 2'd0 ? 64'(32'h0000_A000 | 32'(pos)) : 64'd0);
        end
    endtask

    task automatic expect_rdy(input string tag, input logic e, input logic l, input logic s);
        chk({tag, ".rdy"}, 64'({ex_ready_out, ld_ready_out, st_ready_out}), 64'({e, l, s}));
    endtask

    initial begin
        #2;
        chk("rst.valid", 64'(cdb_valid_out), 64'd0);
        chk("rst.fields", {cdb_src_out, cdb_rob_pos_out, cdb_res_out, cdb_jump_en_out}, 64'd0);
        chk("rst.ja", 64'(cdb_jump_a_out), 64'd0);
        expect_rdy("rst", 1, 1, 1);
        step();
        rst_in = 1'b0;

        ex_valid_in = 1'b1; ex_rob_pos_in = 4'd5; ex_res_in = 32'h1234;
        ex_jump_en_in = 1'b1; ex_jump_a_in = 32'h100;
        step();
        ex_valid_in = 1'b0;
        chk("t1.lat", 64'(cdb_valid_out), 64'd0);
        step();
        chk("t1.valid", 64'(cdb_valid_out), 64'd1);
        chk("t1.src", 64'(cdb_src_out), 64'd0);
        chk("t1.pos", 64'(cdb_rob_pos_out), 64'd5);
        chk("t1.res", 64'(cdb_res_out), 64'h1234);
        chk("t1.jen", 64'(cdb_jump_en_out), 64'd1);
        chk("t1.ja", 64'(cdb_jump_a_out), 64'h100);
        step();
        chk("t1.idle", 64'(cdb_valid_out), 64'd0);
        chk("t1.hold", 64'(cdb_rob_pos_out), 64'd5);

        clear_branch_in = 1'b1;
        step();
        clear_branch_in = 1'b0;
        drive(1, 1, 1, 2, 1, 3);
        step();
        drive(0, 0, 0, 0, 0, 0);
        expect_cdb("t2.push", 0, 0, 0);
        step(); expect_cdb("t2.a", 1, 0, 1);
        step(); expect_cdb("t2.b", 1, 1, 2);
        drive(1, 7, 1, 8, 1, 9);
        step(); expect_cdb("t2.c", 1, 2, 3);
        drive(0, 0, 0, 0, 0, 0);
        step(); expect_cdb("t2.d", 1, 0, 7);
        step(); expect_cdb("t2.e", 1, 1, 8);
        step(); expect_cdb("t2.f", 1, 2, 9);
        step(); expect_cdb("t2.g", 0, 0, 0);

        drive(1, 10, 1, 4, 0, 0); step(); expect_cdb("t3.1", 0, 0, 0);  expect_rdy("t3.1", 1, 1, 1);
        drive(1, 11, 1, 5, 0, 0); step(); expect_cdb("t3.2", 1, 0, 10); expect_rdy("t3.2", 1, 0, 1);
        drive(1, 12, 1, 6, 0, 0); step(); expect_cdb("t3.3", 1, 1, 4);  expect_rdy("t3.3", 0, 1, 1);
        drive(1, 13, 1, 6, 0, 0); step(); expect_cdb("t3.4", 1, 0, 11); expect_rdy("t3.4", 1, 0, 1);
        drive(1, 13, 0, 0, 0, 0); step(); expect_cdb("t3.5", 1, 1, 5);  expect_rdy("t3.5", 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);  step(); expect_cdb("t3.6", 1, 0, 12); expect_rdy("t3.6", 1, 1, 1);
        step(); expect_cdb("t3.7", 1, 1, 6);
        step(); expect_cdb("t3.8", 1, 0, 13);
        step(); expect_cdb("t3.9", 0, 0, 0);

        drive(1, 1, 0, 0, 1, 3); step(); expect_cdb("t4.1", 0, 0, 0);
        drive(1, 2, 0, 0, 1, 4); step(); expect_cdb("t4.2", 1, 2, 3); expect_rdy("t4.2", 0, 1, 1);
        drive(0, 0, 1, 5, 0, 0);
        clear_branch_in = 1'b1;
        step();
        clear_branch_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        expect_cdb("t4.clr", 0, 0, 0);
        expect_rdy("t4.clr", 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            expect_cdb("t4.gone", 0, 0, 0);
        end

        drive(1, 1, 1, 2, 1, 3); step(); expect_cdb("t5.1", 0, 0, 0);
        drive(0, 0, 1, 5, 0, 0); step(); expect_cdb("t5.2", 1, 0, 1); expect_rdy("t5.2", 1, 0, 1);
        rdy_in = 1'b0;
        drive(1, 4, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_cdb("t5.frz", 1, 0, 1);
            expect_rdy("t5.frz", 1, 0, 1);
        end
        rdy_in = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step(); expect_cdb("t5.3", 1, 1, 2);
        step(); expect_cdb("t5.4", 1, 2, 3);
        step(); expect_cdb("t5.5", 1, 1, 5);
        step(); expect_cdb("t5.6", 0, 0, 0);

        drive(1, 1, 1, 2, 0, 0); step(); expect_cdb("t6.1", 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0); step(); expect_cdb("t6.2", 1, 0, 1); expect_rdy("t6.2", 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_in = 1'b1;
        #1;
        chk("t6.rst.valid", 64'(cdb_valid_out), 64'd0);
        chk("t6.rst.pos", 64'(cdb_rob_pos_out), 64'd0);
        expect_rdy("t6.rst", 1, 1, 1);
        #1 rst_in = 1'b0;
        step(); expect_cdb("t6.3", 0, 0, 0);
        drive(1, 6, 0, 0, 0, 0); step(); expect_cdb("t6.4", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); step(); expect_cdb("t6.5", 1, 0, 6);
        step(); expect_cdb("t6.6", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
